// File: rtl/ras_cas_decoder_pkg.sv
// Shared definitions for the VIC DRAM bus decoder: FSM state encodings,
// error codes and the row/column consistency rule.
package ras_cas_decoder_pkg;

    typedef enum logic [1:0] {
        RCD_IDLE = 2'd0,
        RCD_ROW  = 2'd1,
        RCD_COL  = 2'd2,
        RCD_SKIP = 2'd3
    } rcd_state_t;

    localparam logic [1:0] RCD_ERR_TIMEOUT = 2'b00;
    localparam logic [1:0] RCD_ERR_PROTO   = 2'b01;
    localparam logic [1:0] RCD_ERR_COL     = 2'b10;
    localparam logic [1:0] RCD_ERR_REFSEQ  = 2'b11;

    // The column half must repeat the row's top bits and mirror its own nibble.
    function automatic logic col_consistent(input logic [7:0] row, input logic [11:0] col);
        return (col[7:6] == row[7:6]) && (col[11:8] == col[3:0]);
    endfunction

endpackage

// File: rtl/ras_cas_decoder_strobe_edge.sv
// Two-flop registration of an active-low strobe with fall/rise detection.
// Both flops reset high so leaving reset never looks like an edge.
module strobe_edge (
    input  logic clk_dot4x,
    input  logic rst,
    input  logic sig,
    output logic q,
    output logic fall,
    output logic rise
);

    logic p;

    always_ff @(posedge clk_dot4x) begin
        if (rst) begin
            q <= 1'b1;
            p <= 1'b1;
        end else begin
            q <= sig;
            p <= q;
        end
    end

    assign fall = p & ~q;
    assign rise = ~p & q;

endmodule

// File: rtl/ras_cas_decoder.sv
// Receive-side decoder for the VIC multiplexed DRAM bus: rebuilds the
// 14-bit address, reports RAS-only refreshes and flags protocol faults.
module ras_cas_decoder
    import ras_cas_decoder_pkg::*;
#(
    parameter int RAS_TIMEOUT = 31
) (
    input  logic        clk_dot4x,
    input  logic        rst,
    input  logic        ras,
    input  logic        cas,
    input  logic        aec,
    input  logic [11:0] ado,
    output logic [13:0] cap_addr,
    output logic        cap_valid,
    output logic        refresh_valid,
    output logic [7:0]  refresh_row,
    output logic        proto_err,
    output logic [1:0]  err_code
);

    localparam int TW = $clog2(RAS_TIMEOUT + 1);
    localparam logic [TW-1:0] TMAX  = TW'(RAS_TIMEOUT);
    localparam logic [TW-1:0] TLAST = TW'(RAS_TIMEOUT - 1);

    logic        ras_q, ras_fall, ras_rise;
    logic        cas_q, cas_fall, cas_rise;
    logic        aec_q;
    logic [11:0] ado_q;
    logic [7:0]  row, last_ref;
    logic        armed;
    logic [TW-1:0] tcnt;
    rcd_state_t  state, state_next;

    logic timeout, latch_row, capture, refresh;
    logic err_proto, err_col, err_seq, err_any;
    logic [1:0] code_next;
    logic unused_ok;

    strobe_edge u_ras (.clk_dot4x(clk_dot4x), .rst(rst), .sig(ras),
                       .q(ras_q), .fall(ras_fall), .rise(ras_rise));
    strobe_edge u_cas (.clk_dot4x(clk_dot4x), .rst(rst), .sig(cas),
                       .q(cas_q), .fall(cas_fall), .rise(cas_rise));

    // CAS rise carries no meaning for this decoder.
    assign unused_ok = &{1'b0, cas_q, cas_rise};

    always_ff @(posedge clk_dot4x) begin
        if (rst) begin
            aec_q <= 1'b0;
            ado_q <= '0;
        end else begin
            aec_q <= aec;
            ado_q <= ado;
        end
    end

    assign timeout = (state != RCD_IDLE) && !ras_q && (tcnt == TLAST);

    always_ff @(posedge clk_dot4x) begin
        if (rst) state <= RCD_IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            RCD_IDLE: begin
                if (ras_fall && cas_fall) state_next = RCD_SKIP;
                else if (ras_fall)        state_next = aec_q ? RCD_SKIP : RCD_ROW;
            end
            RCD_ROW: begin
                if (cas_fall)      state_next = RCD_COL;
                else if (ras_rise) state_next = RCD_IDLE;
            end
            RCD_COL, RCD_SKIP: begin
                if (ras_rise) state_next = RCD_IDLE;
            end
            default: state_next = RCD_IDLE;
        endcase
        if (timeout) state_next = RCD_IDLE;
    end

    always_comb begin
        latch_row = 1'b0;
        capture   = 1'b0;
        refresh   = 1'b0;
        err_proto = 1'b0;
        err_col   = 1'b0;
        err_seq   = 1'b0;
        case (state)
            RCD_IDLE: begin
                if (cas_fall)                 err_proto = 1'b1;
                else if (ras_fall && !aec_q)  latch_row = 1'b1;
            end
            RCD_ROW: begin
                if (cas_fall) begin
                    capture = 1'b1;
                    err_col = !col_consistent(row, ado_q);
                end else if (ras_rise) begin
                    refresh = 1'b1;
                    err_seq = armed && (row != last_ref - 8'd1);
                end
            end
            default: ;
        endcase
        // A timeout abandons whatever the strobes were doing this cycle.
        if (timeout) begin
            capture = 1'b0;
            refresh = 1'b0;
            err_col = 1'b0;
            err_seq = 1'b0;
        end
        err_any = err_proto | timeout | err_col | err_seq;
        if (err_proto)    code_next = RCD_ERR_PROTO;
        else if (timeout) code_next = RCD_ERR_TIMEOUT;
        else if (err_col) code_next = RCD_ERR_COL;
        else              code_next = RCD_ERR_REFSEQ;
    end

    always_ff @(posedge clk_dot4x) begin
        if (rst) begin
            row           <= '0;
            last_ref      <= '0;
            armed         <= 1'b0;
            tcnt          <= '0;
            cap_addr      <= '0;
            cap_valid     <= 1'b0;
            refresh_valid <= 1'b0;
            refresh_row   <= '0;
            proto_err     <= 1'b0;
            err_code      <= '0;
        end else begin
            cap_valid     <= capture;
            refresh_valid <= refresh;
            proto_err     <= err_any;
            if (latch_row) row <= ado_q[7:0];
            if (state == RCD_IDLE)          tcnt <= '0;
            else if (!ras_q && tcnt != TMAX) tcnt <= tcnt + 1'b1;
            if (capture) cap_addr <= {ado_q[5:0], row};
            if (refresh) begin
                refresh_row <= row;
                last_ref    <= row;
                armed       <= 1'b1;
            end
            if (err_any) err_code <= code_next;
        end
    end

endmodule

// File: tb/tb_ras_cas_decoder.sv
// Directed bench for ras_cas_decoder: bus cycles driven on the falling edge,
// pulses tallied shortly after each rising edge.
module tb_ras_cas_decoder;

    logic        clk_dot4x = 1'b0;
    logic        rst = 1'b1;
    logic        ras = 1'b1;
    logic        cas = 1'b1;
    logic        aec = 1'b0;
    logic [11:0] ado = '0;
    logic [13:0] cap_addr;
    logic        cap_valid;
    logic        refresh_valid;
    logic [7:0]  refresh_row;
    logic        proto_err;
    logic [1:0]  err_code;

    int total = 0;
    int bad = 0;

    int n_cap = 0, n_ref = 0, n_err = 0;
    logic [13:0] last_cap = '0;
    logic [7:0]  last_row = '0;
    logic [1:0]  last_code = '0;

    ras_cas_decoder #(.RAS_TIMEOUT(31)) dut (
        .clk_dot4x(clk_dot4x), .rst(rst), .ras(ras), .cas(cas), .aec(aec), .ado(ado),
        .cap_addr(cap_addr), .cap_valid(cap_valid), .refresh_valid(refresh_valid),
        .refresh_row(refresh_row), .proto_err(proto_err), .err_code(err_code)
    );

    always #5 clk_dot4x = ~clk_dot4x;

    // Pulse monitor: a pulse wider than one cycle is tallied more than once.
    always @(posedge clk_dot4x) begin
        #2;
        if (cap_valid)     begin n_cap++; last_cap = cap_addr; end
        if (refresh_valid) begin n_ref++; last_row = refresh_row; end
        if (proto_err)     begin n_err++; last_code = err_code; end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk_dot4x);
    endtask

    task automatic read_cycle(input logic [11:0] r, input logic [11:0] c, input logic a);
        ado = r; aec = a; ras = 1'b0;
        cyc(4);
        ado = c; cas = 1'b0;
        cyc(4);
        ras = 1'b1; cas = 1'b1; aec = 1'b0;
        cyc(4);
    endtask

    task automatic refresh_cycle(input logic [7:0] r);
        ado = {4'h0, r}; ras = 1'b0;
        cyc(4);
        ras = 1'b1;
        cyc(4);
    endtask

    task automatic test_reset;
        rst = 1'b1;
        cyc(3);
        total++; if (cap_addr !== 14'h0)   begin bad++; $display("FAIL reset_cap_addr got=%h exp=0", cap_addr); end
        total++; if (cap_valid !== 1'b0)   begin bad++; $display("FAIL reset_cap_valid got=%b exp=0", cap_valid); end
        total++; if (refresh_valid !== 1'b0) begin bad++; $display("FAIL reset_refresh_valid got=%b exp=0", refresh_valid); end
        total++; if (refresh_row !== 8'h0) begin bad++; $display("FAIL reset_refresh_row got=%h exp=0", refresh_row); end
        total++; if (proto_err !== 1'b0)   begin bad++; $display("FAIL reset_proto_err got=%b exp=0", proto_err); end
        total++; if (err_code !== 2'b00)   begin bad++; $display("FAIL reset_err_code got=%b exp=00", err_code); end
        rst = 1'b0;
        cyc(4);
        total++; if (n_cap + n_ref + n_err !== 0) begin bad++; $display("FAIL reset_no_pulses got=%0d exp=0", n_cap + n_ref + n_err); end
    endtask

    task automatic test_read;
        int c0 = n_cap, e0 = n_err;
        read_cycle(12'h034, 12'hC0C, 1'b0);
        total++; if (n_cap - c0 !== 1)     begin bad++; $display("FAIL read_cap_count got=%0d exp=1", n_cap - c0); end
        total++; if (last_cap !== 14'h0C34) begin bad++; $display("FAIL read_cap_addr got=%h exp=0c34", last_cap); end
        total++; if (n_err - e0 !== 0)     begin bad++; $display("FAIL read_no_err got=%0d exp=0", n_err - e0); end
    endtask

    task automatic test_mismatch;
        int c0 = n_cap, e0 = n_err;
        read_cycle(12'h0FF, 12'h03F, 1'b0);
        total++; if (n_cap - c0 !== 1)      begin bad++; $display("FAIL mismatch_cap_count got=%0d exp=1", n_cap - c0); end
        total++; if (last_cap !== 14'h3FFF) begin bad++; $display("FAIL mismatch_cap_addr got=%h exp=3fff", last_cap); end
        total++; if (n_err - e0 !== 1)      begin bad++; $display("FAIL mismatch_err_count got=%0d exp=1", n_err - e0); end
        total++; if (last_code !== 2'b10)   begin bad++; $display("FAIL mismatch_err_code got=%b exp=10", last_code); end
    endtask

    task automatic test_refresh_chain;
        logic [7:0] rows [4] = '{8'h01, 8'h00, 8'hFF, 8'hFD};
        int exp_err [4] = '{0, 0, 0, 1};
        int r0 = n_ref, e0 = n_err;
        for (int i = 0; i < 4; i++) begin
            refresh_cycle(rows[i]);
            total++; if (last_row !== rows[i]) begin bad++; $display("FAIL refresh_row[%0d] got=%h exp=%h", i, last_row, rows[i]); end
            total++; if (n_err - e0 !== exp_err[i]) begin bad++; $display("FAIL refresh_err[%0d] got=%0d exp=%0d", i, n_err - e0, exp_err[i]); end
        end
        total++; if (n_ref - r0 !== 4)    begin bad++; $display("FAIL refresh_count got=%0d exp=4", n_ref - r0); end
        total++; if (last_code !== 2'b11) begin bad++; $display("FAIL refresh_err_code got=%b exp=11", last_code); end
    endtask

    task automatic test_cpu_cycle;
        int c0 = n_cap, r0 = n_ref, e0 = n_err;
        read_cycle(12'h100, 12'h0C0, 1'b1);
        total++; if ((n_cap - c0) + (n_ref - r0) + (n_err - e0) !== 0) begin
            bad++; $display("FAIL cpu_no_pulses got=%0d exp=0", (n_cap - c0) + (n_ref - r0) + (n_err - e0));
        end
    endtask

    task automatic test_cas_without_ras;
        int c0 = n_cap, e0 = n_err;
        cas = 1'b0; cyc(4); cas = 1'b1; cyc(4);
        total++; if (n_err - e0 !== 1)    begin bad++; $display("FAIL cas_only_err_count got=%0d exp=1", n_err - e0); end
        total++; if (last_code !== 2'b01) begin bad++; $display("FAIL cas_only_err_code got=%b exp=01", last_code); end
        total++; if (n_cap - c0 !== 0)    begin bad++; $display("FAIL cas_only_no_cap got=%0d exp=0", n_cap - c0); end
    endtask

    task automatic test_simultaneous;
        int c0 = n_cap, r0 = n_ref, e0 = n_err;
        ado = 12'h011; ras = 1'b0; cas = 1'b0; cyc(4);
        ras = 1'b1; cas = 1'b1; cyc(4);
        total++; if (n_err - e0 !== 1)    begin bad++; $display("FAIL simul_err_count got=%0d exp=1", n_err - e0); end
        total++; if (last_code !== 2'b01) begin bad++; $display("FAIL simul_err_code got=%b exp=01", last_code); end
        total++; if ((n_cap - c0) + (n_ref - r0) !== 0) begin bad++; $display("FAIL simul_no_cap got=%0d exp=0", (n_cap - c0) + (n_ref - r0)); end
    endtask

    task automatic test_timeout;
        int c0 = n_cap, r0 = n_ref, e0 = n_err;
        ado = 12'h012; ras = 1'b0;
        cyc(25);
        total++; if (n_err - e0 !== 0)    begin bad++; $display("FAIL timeout_early got=%0d exp=0", n_err - e0); end
        cyc(15);
        total++; if (n_err - e0 !== 1)    begin bad++; $display("FAIL timeout_err_count got=%0d exp=1", n_err - e0); end
        total++; if (last_code !== 2'b00) begin bad++; $display("FAIL timeout_err_code got=%b exp=00", last_code); end
        ras = 1'b1; cyc(4);
        total++; if (n_ref - r0 !== 0)    begin bad++; $display("FAIL timeout_no_refresh got=%0d exp=0", n_ref - r0); end
        read_cycle(12'h034, 12'hC0C, 1'b0);
        total++; if (n_cap - c0 !== 1 || last_cap !== 14'h0C34) begin
            bad++; $display("FAIL timeout_recover got=%0d/%h exp=1/0c34", n_cap - c0, last_cap);
        end
    endtask

    task automatic test_reset_mid;
        int c0, e0;
        ado = 12'h055; ras = 1'b0; cyc(3);
        rst = 1'b1; cyc(2);
        total++; if (cap_addr !== 14'h0 || refresh_row !== 8'h0 || err_code !== 2'b00) begin
            bad++; $display("FAIL mid_reset_outputs got=%h/%h/%b exp=0/0/00", cap_addr, refresh_row, err_code);
        end
        ras = 1'b1; cyc(2);
        c0 = n_cap; e0 = n_err;
        rst = 1'b0; cyc(6);
        total++; if ((n_cap - c0) + (n_err - e0) !== 0) begin bad++; $display("FAIL mid_reset_no_pulse got=%0d exp=0", (n_cap - c0) + (n_err - e0)); end
        read_cycle(12'h02A, 12'h525, 1'b0);
        total++; if (n_cap - c0 !== 1 || last_cap !== 14'h252A) begin
            bad++; $display("FAIL mid_reset_read got=%0d/%h exp=1/252a", n_cap - c0, last_cap);
        end
        total++; if (n_err - e0 !== 0) begin bad++; $display("FAIL mid_reset_read_err got=%0d exp=0", n_err - e0); end
    endtask

    task automatic test_back_to_back;
        int c0 = n_cap, r0 = n_ref, e0 = n_err;
        refresh_cycle(8'h40);
        refresh_cycle(8'h3F);
        read_cycle(12'h0C1, 12'hAEA, 1'b0);
        total++; if (n_ref - r0 !== 2)  begin bad++; $display("FAIL b2b_ref_count got=%0d exp=2", n_ref - r0); end
        total++; if (n_err - e0 !== 0)  begin bad++; $display("FAIL b2b_err_count got=%0d exp=0", n_err - e0); end
        total++; if (n_cap - c0 !== 1 || last_cap !== 14'h2AC1) begin
            bad++; $display("FAIL b2b_read got=%0d/%h exp=1/2ac1", n_cap - c0, last_cap);
        end
    endtask

    initial begin
        cyc(1);
        test_reset;
        test_read;
        test_mismatch;
        test_refresh_chain;
        test_cpu_cycle;
        test_cas_without_ras;
        test_simultaneous;
        test_timeout;
        test_reset_mid;
        test_back_to_back;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
